// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared types and constants for the SPI master controller
package spi_master_pkg;

    localparam int SPI_DATA_W = 64;
    localparam int DEF_DIV    = 2;
    localparam int DEF_SS_NUM = 8;
    localparam int DEF_LEN_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        RESP
    } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - command/response channel between requester and SPI master
interface spi_master_ctrl_if
    import spi_master_pkg::*;
#(
    parameter int SS_NUM = DEF_SS_NUM,
    parameter int LEN_W  = DEF_LEN_W
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SS_NUM-1:0]     cmd_ss;
    logic [LEN_W-1:0]      cmd_len;
    logic [SPI_DATA_W-1:0] cmd_txd;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [SPI_DATA_W-1:0] rsp_rxd;

    modport master (
        output cmd_valid, cmd_ss, cmd_len, cmd_txd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rxd
    );

    modport slave (
        input  cmd_valid, cmd_ss, cmd_len, cmd_txd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rxd
    );

endinterface

// File: rtl/spi_master_ctrl_clk_div.sv
// rtl/spi_master_ctrl_clk_div.sv - SCK half-period tick generator, restarts when enabled
module spi_clk_div #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    logic [7:0] r_cnt;

    // Counter is parked at zero while disabled so the first half-period is always full length.
    assign o_tick = i_en && (r_cnt == 8'(DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode-0 SPI master: command in, full-duplex transfer, response out
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int DIV    = DEF_DIV,
    parameter int SS_NUM = DEF_SS_NUM,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    spi_master_ctrl_if.slave  bus,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [SS_NUM-1:0] ss_n
);

    spi_state_e            r_state;
    logic [LEN_W-1:0]      r_cnt;
    logic [SPI_DATA_W-1:0] r_tx;
    logic [SPI_DATA_W-1:0] r_rx;
    logic                  r_last;
    logic                  r_sck;
    logic                  r_mosi;
    logic [SS_NUM-1:0]     r_ss_n;
    logic                  r_rsp_valid;
    logic [SPI_DATA_W-1:0] r_rsp_rxd;

    logic                  w_en;
    logic                  w_tick;
    logic [LEN_W-1:0]      w_cnt_dec;

    assign w_en      = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_cnt_dec = r_cnt - LEN_W'(1);

    spi_clk_div #(.DIV(DIV)) u_clk_div (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rxd   = r_rsp_rxd;
    assign sck           = r_sck;
    assign mosi          = r_mosi;
    assign ss_n          = r_ss_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_last      <= 1'b0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b1;
            r_ss_n      <= '1;
            r_rsp_valid <= 1'b0;
            r_rsp_rxd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_tx    <= bus.cmd_txd;
                        r_cnt   <= bus.cmd_len;
                        r_rx    <= '0;
                        r_last  <= 1'b0;
                        r_ss_n  <= ~bus.cmd_ss;
                        r_mosi  <= bus.cmd_txd[bus.cmd_len];
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sck   <= 1'b1;
                        r_rx    <= {r_rx[SPI_DATA_W-2:0], miso};
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            if (r_cnt == '0) begin
                                r_last <= 1'b1;
                            end else begin
                                r_cnt  <= w_cnt_dec;
                                r_mosi <= r_tx[w_cnt_dec];
                            end
                        end else if (r_last) begin
                            // Last bit's low phase is complete; SS stays asserted through HOLD.
                            r_state <= HOLD;
                        end else begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[SPI_DATA_W-2:0], miso};
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_ss_n      <= '1;
                        r_mosi      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rxd   <= r_rx;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI master controller that sequences full-duplex transfers to the SoC's SPI slave peripherals (bit-reverser, flash and similar). A requester issues one command per transfer: slave select, bit count and transmit data. The block generates SCK, MOSI and active-low SS, samples MISO, and returns the received bits on a response channel. It is the single master in front of the SPI bus, between the bus-side register/adapter logic and the slave pins.

## Interface
- `DIV`, default 2: SCK half-period in `clock` cycles; legal range 1..255.
- `SS_NUM`, default 8: number of slave-select lines.
- `LEN_W`, default 6: command length field width; the maximum transfer is 2^LEN_W bits (64).
- `clock` input, 1 bit: sole clock.
- `reset` input, 1 bit: reset, asynchronous and active-high.
- `cmd_valid` input, 1 bit: a command is offered.
- `cmd_ready` output, 1 bit: the controller can accept a command.
- `cmd_ss` input, SS_NUM bits: one-hot/any set of slaves to select; bit i drives `ss_n[i]` low.
- `cmd_len` input, LEN_W bits: transfer length minus 1, in bits.
- `cmd_txd` input, 64 bits: transmit data, right-aligned; bit `cmd_len` is sent first (MSB first).
- `rsp_valid` output, 1 bit: received data is available.
- `rsp_ready` input, 1 bit: the requester accepts the response.
- `rsp_rxd` output, 64 bits: received bits, right-aligned; bits above `cmd_len` are zero.
- `sck` output, 1 bit: SPI clock, mode 0 (idles low).
- `mosi` output, 1 bit: master out.
- `miso` input, 1 bit: master in.
- `ss_n` output, SS_NUM bits: active-low slave selects.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, RESP.
- IDLE:
  - `cmd_ready` = 1 (combinational from state).
  - On `cmd_valid && cmd_ready`, latch ss, len and txd; go to SETUP.
- SETUP: drive `ss_n = ~cmd_ss` and `mosi = txd[len]`; `sck` stays 0 for DIV cycles; then go to SHIFT.
- SHIFT, per bit:
  - `sck` goes 1 for DIV cycles, then 0 for DIV cycles.
  - On the cycle `sck` rises, capture `miso`, shifting it into the LSB of the rx register.
  - On the cycle `sck` falls, advance `mosi` to the next lower tx bit.
  - After bit 0's falling edge, go to HOLD; `mosi` is not advanced after the last bit.
- HOLD: `sck` = 0 and ss is still asserted for DIV cycles; then drive `ss_n` all-ones and go to RESP.
- RESP:
  - `rsp_valid` = 1 and `rsp_rxd` stays stable until `rsp_ready`.
  - On the handshake cycle, go to IDLE.
  - A new command can be accepted the cycle after.
- Bit counter: LEN_W bits, counting down from len to 0, with no wrap.
- `cmd_len` = 0 gives a 1-bit transfer. `cmd_len` = all-ones gives 2^LEN_W bits.
- `cmd_ss` = 0 is legal: a full clocked transfer runs with no slave selected, and `rsp_rxd` holds whatever `miso` carried.
- Commands presented outside IDLE are ignored (`cmd_ready` = 0). `cmd_*` is sampled only on the handshake.

## Timing
- Reset values, applied asynchronously and held while `reset` = 1:
  - state = IDLE, so `cmd_ready` = 1.
  - `sck` = 0, `mosi` = 1, `ss_n` = all-ones.
  - `rsp_valid` = 0, `rsp_rxd` = 0.
- Reset mid-transfer: SS deasserts and SCK drops immediately. No response is produced for the aborted command.
- Latency is measured from the handshake cycle to the first `rsp_valid` cycle: 1 + DIV + 2·DIV·(len+1) + DIV cycles.
  - Example: DIV = 2, 8 bits gives 1 + 2 + 32 + 2 = 37.
- All outputs are registered except `cmd_ready`.
- `ss_n` and `mosi` change only on `sck` falling edges or while `sck` = 0.
- Setup and hold of SS around the first and last SCK edge are each ≥ DIV cycles.
- `miso` is sampled in the `clock` cycle in which the `sck` register transitions 0→1, i.e. at the value present just before that edge.

## Structure
- Package `spi_master_pkg` holds:
  - the state enum: IDLE/SETUP/SHIFT/HOLD/RESP;
  - `SPI_DATA_W = 64`;
  - the default DIV, SS_NUM and LEN_W constants.
- Sub-module `spi_clk_div`:
  - a DIV-cycle half-period counter;
  - enabled outside IDLE/RESP;
  - emits a one-cycle `tick` per half-period;
  - restarts on enable rise.
- The FSM, shift registers and bit counter stay in `spi_master_ctrl`.

## Test plan
- Loopback (`miso` = `mosi`), DIV = 2: command ss = 0x01, len = 7, txd = 0xA5.
  - Expect `rsp_rxd` = 0xA5.
  - Expect `rsp_valid` exactly 37 cycles after the handshake.
  - Expect 8 SCK pulses, each 2 high + 2 low cycles.
  - Expect `ss_n` = 0xFE only during the transfer.
- Bit-reverser slave model on ss[0]: command len = 15, txd = 0x1300.
  - Expect `rsp_rxd[7:0]` = 0xC8 and `rsp_rxd[15:8]` = 0xFF (idle-high MISO during the receive byte).
- Boundary lengths, loopback:
  - len = 0, txd = 1 → `rsp_rxd` = 0x1.
  - len = 63, txd = 0xDEADBEEF_01234567 → same value returned.
  - txd bits above len are ignored: len = 3, txd = 0xFF → `rsp_rxd` = 0xF.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles.
  - `rsp_valid` and `rsp_rxd` stay stable.
  - `cmd_ready` stays 0 and a concurrently offered command is not accepted.
  - It is accepted one cycle after the `rsp_ready` handshake.
- Reset mid-SHIFT (after 3 SCK pulses):
  - Outputs go immediately to `sck` = 0, `ss_n` = all-ones, `mosi` = 1, `rsp_valid` = 0, `cmd_ready` = 1.
  - The next command (len = 7, txd = 0x3C, loopback) completes with 0x3C.
- DIV = 1, ss = 0x00, len = 7:
  - SCK toggles every cycle and `ss_n` stays all-ones.
  - Response arrives 1 + 1 + 16 + 1 = 19 cycles after the handshake.
